// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states and the queue entry layout.
package ifu_pkg;

  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Registered instruction queue between fetch and decode; flush empties it and wins over push/pop.
module fetch_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output fetch_entry_t           head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count_q != '0) && !flush;
  // A pop in the same cycle frees the slot, so push at full count is still accepted.
  assign do_push = push && !flush && ((count_q != FULL) || do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifu_fetch.sv
// Fetch FSM: REQ issues one word fetch at pc, WAIT takes its single-beat response,
// HALTED stops issuing (queue still drains) until reset.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_err,
  output logic        halted
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  req_pc_q, req_pc_d;
  logic         kill_q, kill_d;
  logic         halt_pend_q, halt_pend_d;
  logic         started_q;
  logic         halt_eff;
  logic         redir;
  logic         req_fire;
  logic         push;
  logic [CW-1:0] q_count;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic [1:0]   unused_rpc_bits;

  assign unused_rpc_bits = redirect_pc[1:0];

  assign halt_eff = halt | halt_pend_q;
  assign redir    = redirect_valid && (state_q != HALTED);

  // started_q keeps the request channel quiet for the first clock after reset.
  assign imem_req_valid = (state_q == REQ) && started_q && !halt_pend_q && (q_count < QFULL);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign halted         = (state_q == HALTED);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    kill_d      = kill_q;
    halt_pend_d = halt_eff;
    push        = 1'b0;
    case (state_q)
      REQ: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 64'd4;
          kill_d   = redir;
          state_d  = WAIT;
        end else if (halt_eff) begin
          state_d = HALTED;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          push    = !kill_q;
          kill_d  = 1'b0;
          state_d = halt_eff ? HALTED : REQ;
        end else if (redir) begin
          kill_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (redir) pc_d = {redirect_pc[63:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      kill_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      kill_q      <= kill_d;
      halt_pend_q <= halt_pend_d;
      started_q   <= 1'b1;
    end
  end

  assign push_entry = '{inst: imem_rsp_data, pc: req_pc_q, err: imem_rsp_err};

  fetch_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (inst_ready),
    .flush      (redir),
    .count      (q_count),
    .head_valid (inst_valid),
    .head       (head)
  );

  assign inst     = head.inst;
  assign inst_pc  = head.pc;
  assign inst_err = head.err;

endmodule
